open_list_writer: RTL and testbench

//  Owns the A* open list (parallel X/Y coordinate arrays) and is its only writer.

---
 rtl/open_list_if.sv | 33 +++
 rtl/open_list_writer.sv | 178 +++++++++++++++++
 tb/tb_open_list_writer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/open_list_if.sv
// Command, status and read-port bundle between the planner/searcher and the open-list writer.
interface open_list_if #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned IDX_W   = 9
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;
    logic [IDX_W-1:0]   cmd_index;
    logic               done;
    logic               err;
    logic [IDX_W-1:0]   count;
    logic               full;
    logic               empty;
    logic [IDX_W-1:0]   rd_index;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               rd_valid;

    // Planner FSM and searcher side
    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_index, rd_index,
        input  cmd_ready, done, err, count, full, empty, rd_x, rd_y, rd_valid
    );

    // Open-list writer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_index, rd_index,
        output cmd_ready, done, err, count, full, empty, rd_x, rd_y, rd_valid
    );
endinterface

// File: rtl/open_list_writer.sv
// Sole writer of the A* open list. Keeps entries 0..count-1 packed; removal swaps the
// last live entry into the hole. One command in flight; combinational read port.
module open_list_writer #(
    parameter int unsigned DEPTH   = 400,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned IDX_W   = 9
) (
    input  logic        Clk,
    input  logic        Reset_n,
    open_list_if.slave  bus
);

    localparam logic [1:0]       OpInsert   = 2'b00;
    localparam logic [1:0]       OpRemoveAt = 2'b01;
    localparam logic [1:0]       OpClear    = 2'b10;
    localparam logic [1:0]       OpWriteAt  = 2'b11;
    localparam logic [IDX_W-1:0] DepthIdx   = IDX_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StExec, StMove, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0]         op_q, op_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] tmp_x_q, tmp_x_d, tmp_y_q, tmp_y_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    logic [COORD_W-1:0] openx_q [DEPTH];
    logic [COORD_W-1:0] openy_q [DEPTH];

    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic [COORD_W-1:0] wr_x, wr_y;

    logic               accept;
    logic               is_full;
    logic               idx_ok;
    logic [IDX_W-1:0]   last_idx;

    assign is_full  = (count_q == DepthIdx);
    assign idx_ok   = (idx_q < count_q);
    assign last_idx = count_q - IDX_W'(1);
    assign accept   = (state_q == StIdle) && bus.cmd_valid;

    // FSM state register; reset aborts any command in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // FSM next-state: only a valid REMOVE_AT needs the extra MOVE cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus.cmd_valid) state_d = StExec;
            StExec: state_d = (op_q == OpRemoveAt && idx_ok) ? StMove : StDone;
            StMove: state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: handshake, completion pulse and array write port
    always_comb begin
        bus.cmd_ready = (state_q == StIdle);
        bus.done      = (state_q == StDone);
        wr_en         = 1'b0;
        wr_idx        = count_q;
        wr_x          = x_q;
        wr_y          = y_q;
        unique case (state_q)
            StExec: begin
                if (op_q == OpInsert && !is_full) begin
                    wr_en  = 1'b1;
                    wr_idx = count_q;
                end else if (op_q == OpWriteAt && idx_ok) begin
                    wr_en  = 1'b1;
                    wr_idx = idx_q;
                end
            end
            StMove: begin
                wr_en  = 1'b1;
                wr_idx = idx_q;
                wr_x   = tmp_x_q;
                wr_y   = tmp_y_q;
            end
            default: ;
        endcase
    end

    // Datapath next-state: command latch, error flag, swap temp and live count
    always_comb begin
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        tmp_x_d = tmp_x_q;
        tmp_y_d = tmp_y_q;
        count_d = count_q;
        err_d   = err_q;
        if (accept) begin
            op_d  = bus.cmd_op;
            x_d   = bus.cmd_x;
            y_d   = bus.cmd_y;
            idx_d = bus.cmd_index;
            err_d = 1'b0;
        end
        if (state_q == StExec) begin
            unique case (op_q)
                OpInsert: begin
                    if (is_full) err_d   = 1'b1;
                    else         count_d = count_q + IDX_W'(1);
                end
                OpRemoveAt: begin
                    if (!idx_ok) begin
                        err_d = 1'b1;
                    end else begin
                        tmp_x_d = openx_q[last_idx];
                        tmp_y_d = openy_q[last_idx];
                    end
                end
                OpClear:   count_d = '0;
                OpWriteAt: if (!idx_ok) err_d = 1'b1;
                default: ;
            endcase
        end
        if (state_q == StMove && count_q != '0) count_d = count_q - IDX_W'(1);
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_q    <= OpInsert;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            tmp_x_q <= '0;
            tmp_y_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            tmp_x_q <= tmp_x_d;
            tmp_y_q <= tmp_y_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Coordinate arrays; contents survive reset since only entries below count matter
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            openx_q[wr_idx] <= wr_x;
            openy_q[wr_idx] <= wr_y;
        end
    end

    // Status and combinational read port; out-of-range addresses read as zero
    always_comb begin
        bus.err      = err_q;
        bus.count    = count_q;
        bus.full     = is_full;
        bus.empty    = (count_q == '0);
        bus.rd_valid = (bus.rd_index < count_q);
        bus.rd_x     = '0;
        bus.rd_y     = '0;
        if (bus.rd_index < DepthIdx) begin
            bus.rd_x = openx_q[bus.rd_index];
            bus.rd_y = openy_q[bus.rd_index];
        end
    end

endmodule

// File: tb/tb_open_list_writer.sv
// Directed self-checking bench for open_list_writer.
module tb_open_list_writer;

    localparam logic [1:0] OpInsert   = 2'b00;
    localparam logic [1:0] OpRemoveAt = 2'b01;
    localparam logic [1:0] OpClear    = 2'b10;
    localparam logic [1:0] OpWriteAt  = 2'b11;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   nchk = 0;
    int   nfail = 0;

    open_list_if #(.COORD_W(8), .IDX_W(9)) bus ();

    open_list_writer #(.DEPTH(400), .COORD_W(8), .IDX_W(9)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // Issue one command; lat counts edges from the accept edge to the done-high cycle.
    task automatic send(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                        input logic [8:0] idx, output int lat, output logic e);
        int guard;
        @(negedge Clk);
        bus.cmd_op = op; bus.cmd_x = x; bus.cmd_y = y; bus.cmd_index = idx;
        bus.cmd_valid = 1'b1;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 10) begin
            @(negedge Clk); guard++;
        end
        @(posedge Clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 0; e = 1'bx;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            lat = i + 2;
            if (bus.done === 1'b1) begin
                e = bus.err;
                break;
            end
        end
        if (bus.done !== 1'b1) begin
            $display("FAIL done_timeout op=%0d got done=%b want 1", op, bus.done);
            nfail++; lat = -1;
        end
        nchk++;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0; bus.cmd_valid = 1'b0; bus.rd_index = '0;
        bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_index = '0;
        repeat (3) @(posedge Clk);
        #1;
        nchk++; if (bus.cmd_ready !== 1'b1) begin $display("FAIL rst_ready got %b want 1", bus.cmd_ready); nfail++; end
        nchk++; if (bus.done !== 1'b0) begin $display("FAIL rst_done got %b want 0", bus.done); nfail++; end
        nchk++; if (bus.err !== 1'b0) begin $display("FAIL rst_err got %b want 0", bus.err); nfail++; end
        nchk++; if (bus.count !== 9'd0) begin $display("FAIL rst_count got %0d want 0", bus.count); nfail++; end
        nchk++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            $display("FAIL rst_flags got empty=%b full=%b want 1 0", bus.empty, bus.full); nfail++; end
        @(negedge Clk); Reset_n = 1'b1;
    endtask

    task automatic test_insert;
        int lat; logic e;
        send(OpInsert, 8'd3, 8'd4, 9'd0, lat, e);
        nchk++; if (lat != 2) begin $display("FAIL ins_latency got %0d want 2", lat); nfail++; end
        nchk++; if (e !== 1'b0) begin $display("FAIL ins_err got %b want 0", e); nfail++; end
        @(posedge Clk); #1;
        nchk++; if (bus.done !== 1'b0) begin $display("FAIL done_pulse got %b want 0", bus.done); nfail++; end
        send(OpInsert, 8'd5, 8'd6, 9'd0, lat, e);
        nchk++; if (bus.count !== 9'd2) begin $display("FAIL ins_count got %0d want 2", bus.count); nfail++; end
        bus.rd_index = 9'd1; #1;
        nchk++; if (bus.rd_x !== 8'd5 || bus.rd_y !== 8'd6 || bus.rd_valid !== 1'b1) begin
            $display("FAIL ins_rd1 got (%0d,%0d) v=%b want (5,6) v=1", bus.rd_x, bus.rd_y, bus.rd_valid); nfail++; end
        bus.rd_index = 9'd0; #1;
        nchk++; if (bus.rd_x !== 8'd3 || bus.rd_y !== 8'd4) begin
            $display("FAIL ins_rd0 got (%0d,%0d) want (3,4)", bus.rd_x, bus.rd_y); nfail++; end
        bus.rd_index = 9'd2; #1;
        nchk++; if (bus.rd_valid !== 1'b0) begin $display("FAIL ins_rdvalid2 got %b want 0", bus.rd_valid); nfail++; end
    endtask

    task automatic test_fill;
        int lat; logic e;
        send(OpClear, 8'd0, 8'd0, 9'd0, lat, e);
        for (int i = 0; i < 400; i++) begin
            logic [8:0] iv;
            iv = 9'(i);
            send(OpInsert, iv[7:0], ~iv[7:0], 9'd0, lat, e);
        end
        nchk++; if (bus.count !== 9'd400 || bus.full !== 1'b1) begin
            $display("FAIL fill_count got %0d full=%b want 400 1", bus.count, bus.full); nfail++; end
        send(OpInsert, 8'd9, 8'd9, 9'd0, lat, e);
        nchk++; if (e !== 1'b1) begin $display("FAIL full_err got %b want 1", e); nfail++; end
        nchk++; if (bus.count !== 9'd400 || bus.full !== 1'b1) begin
            $display("FAIL full_count got %0d full=%b want 400 1", bus.count, bus.full); nfail++; end
        bus.rd_index = 9'd399; #1;
        nchk++; if (bus.rd_x !== 8'd143 || bus.rd_y !== 8'd112) begin
            $display("FAIL full_rd399 got (%0d,%0d) want (143,112)", bus.rd_x, bus.rd_y); nfail++; end
    endtask

    task automatic test_remove;
        int lat; logic e;
        send(OpClear, 8'd0, 8'd0, 9'd0, lat, e);
        send(OpInsert, 8'd1, 8'd1, 9'd0, lat, e);
        send(OpInsert, 8'd2, 8'd2, 9'd0, lat, e);
        send(OpInsert, 8'd3, 8'd3, 9'd0, lat, e);
        send(OpRemoveAt, 8'd0, 8'd0, 9'd0, lat, e);
        nchk++; if (lat != 3) begin $display("FAIL rm_latency got %0d want 3", lat); nfail++; end
        nchk++; if (e !== 1'b0) begin $display("FAIL rm_err got %b want 0", e); nfail++; end
        nchk++; if (bus.count !== 9'd2) begin $display("FAIL rm_count got %0d want 2", bus.count); nfail++; end
        bus.rd_index = 9'd0; #1;
        nchk++; if (bus.rd_x !== 8'd3 || bus.rd_y !== 8'd3) begin
            $display("FAIL rm_rd0 got (%0d,%0d) want (3,3)", bus.rd_x, bus.rd_y); nfail++; end
        bus.rd_index = 9'd1; #1;
        nchk++; if (bus.rd_x !== 8'd2 || bus.rd_y !== 8'd2) begin
            $display("FAIL rm_rd1 got (%0d,%0d) want (2,2)", bus.rd_x, bus.rd_y); nfail++; end
    endtask

    task automatic test_err_write;
        int lat; logic e;
        send(OpRemoveAt, 8'd0, 8'd0, 9'd5, lat, e);
        nchk++; if (e !== 1'b1 || lat != 2) begin
            $display("FAIL rm_oob got err=%b lat=%0d want 1 2", e, lat); nfail++; end
        nchk++; if (bus.count !== 9'd2) begin $display("FAIL rm_oob_count got %0d want 2", bus.count); nfail++; end
        bus.rd_index = 9'd0; #1;
        nchk++; if (bus.rd_x !== 8'd3 || bus.rd_y !== 8'd3) begin
            $display("FAIL rm_oob_rd0 got (%0d,%0d) want (3,3)", bus.rd_x, bus.rd_y); nfail++; end
        send(OpWriteAt, 8'd7, 8'd7, 9'd1, lat, e);
        nchk++; if (e !== 1'b0 || lat != 2) begin
            $display("FAIL wr_at got err=%b lat=%0d want 0 2", e, lat); nfail++; end
        bus.rd_index = 9'd1; #1;
        nchk++; if (bus.rd_x !== 8'd7 || bus.rd_y !== 8'd7 || bus.count !== 9'd2) begin
            $display("FAIL wr_at_rd1 got (%0d,%0d) cnt=%0d want (7,7) 2", bus.rd_x, bus.rd_y, bus.count); nfail++; end
        send(OpWriteAt, 8'd8, 8'd8, 9'd2, lat, e);
        nchk++; if (e !== 1'b1) begin $display("FAIL wr_oob got err=%b want 1", e); nfail++; end
    endtask

    task automatic test_clear;
        int lat; logic e;
        send(OpClear, 8'd0, 8'd0, 9'd0, lat, e);
        nchk++; if (e !== 1'b0 || lat != 2) begin
            $display("FAIL clr got err=%b lat=%0d want 0 2", e, lat); nfail++; end
        bus.rd_index = 9'd0; #1;
        nchk++; if (bus.count !== 9'd0 || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin
            $display("FAIL clr_state got cnt=%0d empty=%b rdv=%b want 0 1 0", bus.count, bus.empty, bus.rd_valid);
            nfail++; end
        send(OpClear, 8'd0, 8'd0, 9'd0, lat, e);
        nchk++; if (e !== 1'b0) begin $display("FAIL clr_empty_err got %b want 0", e); nfail++; end
    endtask

    task automatic test_reset_mid;
        int lat; logic e; int seen;
        send(OpInsert, 8'd1, 8'd1, 9'd0, lat, e);
        send(OpInsert, 8'd2, 8'd2, 9'd0, lat, e);
        send(OpInsert, 8'd3, 8'd3, 9'd0, lat, e);
        @(negedge Clk);
        bus.cmd_op = OpRemoveAt; bus.cmd_index = 9'd0; bus.cmd_valid = 1'b1;
        @(posedge Clk); #1;          // accepted, now in EXEC
        bus.cmd_valid = 1'b0;
        @(posedge Clk); #1;          // now in MOVE
        Reset_n = 1'b0; #1;
        nchk++; if (bus.count !== 9'd0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            $display("FAIL mid_rst got cnt=%0d done=%b rdy=%b want 0 0 1", bus.count, bus.done, bus.cmd_ready);
            nfail++; end
        @(negedge Clk); Reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            if (bus.done === 1'b1) seen++;
        end
        nchk++; if (seen != 0 || bus.cmd_ready !== 1'b1 || bus.count !== 9'd0) begin
            $display("FAIL mid_rst_after got dones=%0d rdy=%b cnt=%0d want 0 1 0", seen, bus.cmd_ready, bus.count);
            nfail++; end
    endtask

    initial begin
        test_reset;
        test_insert;
        test_fill;
        test_remove;
        test_err_write;
        test_clear;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
